// File: rtl/acq_trigger_ctrl_pkg.sv
// Shared state codes, register map defaults and REQUEST/SETTINGS bit positions
// for the acquisition trigger sequencer.
package acq_trigger_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE_FILL  = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST_FILL = 3'd3,
    ST_DONE      = 3'd4
  } acq_state_e;

  localparam int DEF_ADDR_REQUEST     = 3;
  localparam int DEF_ADDR_SETTINGS    = 4;
  localparam int DEF_ADDR_TRIG_LEVEL  = 5;
  localparam int DEF_ADDR_PRETRIG     = 6;
  localparam int DEF_ADDR_NUM_SAMPLES = 7;

  localparam int REQ_START_BIT = 0;
  localparam int REQ_ABORT_BIT = 1;
  localparam int REQ_FORCE_BIT = 2;
  localparam int SET_EDGE_BIT  = 0;

endpackage

// File: rtl/acq_trigger_ctrl_trigger_detector.sv
// Edge trigger detector: remembers the previous accepted sample and flags the
// current sample as the trigger sample on a level crossing or a force request.
// trig_o is combinational and aligned with sample_i.
module acq_trigger_ctrl_trigger_detector #(
  parameter int BITS_ADC = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                sample_i,
  input  logic                eval_i,
  input  logic [BITS_ADC-1:0] data_i,
  input  logic [BITS_ADC-1:0] level_i,
  input  logic                falling_i,
  input  logic                force_i,
  output logic                trig_o
);

  logic [BITS_ADC-1:0] prev_q;
  logic                prev_valid_q;
  logic                edge_hit;

  // Track the previous sample; it becomes valid after the first sample of a capture
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (sample_i) begin
      prev_q       <= data_i;
      prev_valid_q <= 1'b1;
    end
  end

  // Level crossing compare; only armed samples can raise the trigger
  always_comb begin
    edge_hit = 1'b0;
    if (prev_valid_q) begin
      if (falling_i) edge_hit = (prev_q >= level_i) && (data_i < level_i);
      else           edge_hit = (prev_q < level_i) && (data_i >= level_i);
    end
    trig_o = sample_i && eval_i && (force_i || edge_hit);
  end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Acquisition sequencer: writes the ADC sample stream into a circular capture
// buffer, keeps pre-trigger history, detects an edge trigger and captures the
// post-trigger samples. Configured via the register simple interface.
//
// Handshake: adc_rdy_i is a 1-cycle valid strobe with no back-pressure; an
// accepted sample appears on buf_we_o/buf_addr_o/buf_data_o one cycle later.
// reg_si_rdy is a 1-cycle write strobe; REQUEST writes act in that same cycle.
module acq_trigger_ctrl
  import acq_trigger_ctrl_pkg::*;
#(
  parameter int BITS_ADC            = 8,
  parameter int BUF_ADDR_WIDTH      = 8,
  parameter int REG_DATA_WIDTH      = 16,
  parameter int REG_ADDR_WIDTH      = 8,
  parameter int DEFAULT_TRIG_LEVEL  = 128,
  parameter int DEFAULT_PRETRIG     = 64,
  parameter int DEFAULT_NUM_SAMPLES = 256,
  parameter int ADDR_REQUEST        = DEF_ADDR_REQUEST,
  parameter int ADDR_SETTINGS       = DEF_ADDR_SETTINGS,
  parameter int ADDR_TRIG_LEVEL     = DEF_ADDR_TRIG_LEVEL,
  parameter int ADDR_PRETRIG        = DEF_ADDR_PRETRIG,
  parameter int ADDR_NUM_SAMPLES    = DEF_ADDR_NUM_SAMPLES
) (
  input  logic                      clk_i,
  input  logic                      rst,
  input  logic [BITS_ADC-1:0]       adc_data_i,
  input  logic                      adc_rdy_i,
  input  logic [REG_DATA_WIDTH-1:0] reg_si_data,
  input  logic [REG_ADDR_WIDTH-1:0] reg_si_addr,
  input  logic                      reg_si_rdy,
  output logic                      buf_we_o,
  output logic [BUF_ADDR_WIDTH-1:0] buf_addr_o,
  output logic [BITS_ADC-1:0]       buf_data_o,
  output logic [BUF_ADDR_WIDTH-1:0] start_addr_o,
  output logic [BUF_ADDR_WIDTH-1:0] trig_addr_o,
  output logic                      triggered_o,
  output logic                      done_o,
  output logic [2:0]                state_o
);

  localparam int CW    = BUF_ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << BUF_ADDR_WIDTH;

  // Programmed configuration
  logic                edge_q;
  logic [BITS_ADC-1:0] level_q;
  logic [CW-1:0]       pretrig_q;
  logic [CW-1:0]       num_q;

  // Configuration latched at start
  logic                edge_lat_q;
  logic [BITS_ADC-1:0] level_lat_q;
  logic [CW-1:0]       pre_lat_q;
  logic [CW-1:0]       post_lat_q;

  // Sequencer state
  acq_state_e                state_q;
  logic [BUF_ADDR_WIDTH-1:0] ptr_q;
  logic [BUF_ADDR_WIDTH-1:0] ptr_d;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;
  logic                      force_pend_q;
  logic                      buf_we_q;
  logic [BUF_ADDR_WIDTH-1:0] buf_addr_q;
  logic [BITS_ADC-1:0]       buf_data_q;
  logic [BUF_ADDR_WIDTH-1:0] start_addr_q;
  logic [BUF_ADDR_WIDTH-1:0] trig_addr_q;
  logic                      triggered_q;
  logic                      done_q;

  // Combinational helpers
  logic          req_wr;
  logic          start_req;
  logic          abort_req;
  logic          ctl_req;
  logic          force_now;
  logic          capturing;
  logic          sample_acc;
  logic          trig;
  logic [CW-1:0] reg_field;
  logic [CW-1:0] n_eff;
  logic [CW-1:0] pre_eff;
  logic [CW-1:0] post_len;

  // Decode requests, sample acceptance and the effective capture lengths
  always_comb begin
    req_wr    = reg_si_rdy && (reg_si_addr == REG_ADDR_WIDTH'(ADDR_REQUEST));
    abort_req = req_wr && reg_si_data[REQ_ABORT_BIT];
    start_req = req_wr && reg_si_data[REQ_START_BIT] && !reg_si_data[REQ_ABORT_BIT];
    ctl_req   = start_req || abort_req;
    force_now = req_wr && reg_si_data[REQ_FORCE_BIT] && !ctl_req && (state_q == ST_WAIT_TRIG);
    capturing = (state_q == ST_PRE_FILL) || (state_q == ST_WAIT_TRIG) ||
                (state_q == ST_POST_FILL);
    // A sample colliding with a start/abort write belongs to neither capture
    sample_acc = adc_rdy_i && capturing && !ctl_req;
    ptr_d      = ptr_q + BUF_ADDR_WIDTH'(1);
    cnt_d      = cnt_q + CW'(1);

    // Length fields saturate when the host writes a value wider than the field
    if ((reg_si_data >> CW) != '0) reg_field = '1;
    else                           reg_field = reg_si_data[CW-1:0];

    if (num_q < CW'(2))          n_eff = CW'(2);
    else if (num_q > CW'(DEPTH)) n_eff = CW'(DEPTH);
    else                         n_eff = num_q;
    pre_eff  = (pretrig_q < n_eff) ? pretrig_q : (n_eff - CW'(1));
    post_len = n_eff - pre_eff;
  end

  // Host-programmed configuration registers
  always_ff @(posedge clk_i) begin
    if (rst) begin
      edge_q    <= 1'b0;
      level_q   <= BITS_ADC'(DEFAULT_TRIG_LEVEL);
      pretrig_q <= CW'(DEFAULT_PRETRIG);
      num_q     <= CW'(DEFAULT_NUM_SAMPLES);
    end else if (reg_si_rdy) begin
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_SETTINGS))    edge_q    <= reg_si_data[SET_EDGE_BIT];
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_TRIG_LEVEL))  level_q   <= reg_si_data[BITS_ADC-1:0];
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_PRETRIG))     pretrig_q <= reg_field;
      if (reg_si_addr == REG_ADDR_WIDTH'(ADDR_NUM_SAMPLES)) num_q     <= reg_field;
    end
  end

  acq_trigger_ctrl_trigger_detector #(
    .BITS_ADC (BITS_ADC)
  ) u_trig (
    .clk_i     (clk_i),
    .rst_i     (rst),
    .clear_i   (start_req),
    .sample_i  (sample_acc),
    .eval_i    (state_q == ST_WAIT_TRIG),
    .data_i    (adc_data_i),
    .level_i   (level_lat_q),
    .falling_i (edge_lat_q),
    .force_i   (force_pend_q || force_now),
    .trig_o    (trig)
  );

  // Capture FSM with pointer/counters, write register and sticky status
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      force_pend_q <= 1'b0;
      edge_lat_q   <= 1'b0;
      level_lat_q  <= '0;
      pre_lat_q    <= '0;
      post_lat_q   <= '0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      start_addr_q <= '0;
      trig_addr_q  <= '0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      buf_we_q <= sample_acc;
      if (sample_acc) begin
        buf_addr_q <= ptr_q;
        buf_data_q <= adc_data_i;
        ptr_q      <= ptr_d;
      end

      if (abort_req) begin
        state_q      <= ST_IDLE;
        done_q       <= 1'b0;
        force_pend_q <= 1'b0;
      end else if (start_req) begin
        state_q      <= (pre_eff == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
        ptr_q        <= '0;
        cnt_q        <= '0;
        force_pend_q <= 1'b0;
        done_q       <= 1'b0;
        triggered_q  <= 1'b0;
        edge_lat_q   <= edge_q;
        level_lat_q  <= level_q;
        pre_lat_q    <= pre_eff;
        post_lat_q   <= post_len;
      end else begin
        case (state_q)
          ST_PRE_FILL: begin
            if (sample_acc) begin
              if (cnt_d == pre_lat_q) begin
                state_q <= ST_WAIT_TRIG;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_d;
              end
            end
          end
          ST_WAIT_TRIG: begin
            if (force_now) force_pend_q <= 1'b1;
            if (trig) begin
              force_pend_q <= 1'b0;
              trig_addr_q  <= ptr_q;
              start_addr_q <= ptr_q - pre_lat_q[BUF_ADDR_WIDTH-1:0];
              triggered_q  <= 1'b1;
              if (post_lat_q == CW'(1)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_POST_FILL;
                cnt_q   <= CW'(1);
              end
            end
          end
          ST_POST_FILL: begin
            if (sample_acc) begin
              if (cnt_d == post_lat_q) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_d;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign buf_we_o     = buf_we_q;
  assign buf_addr_o   = buf_addr_q;
  assign buf_data_o   = buf_data_q;
  assign start_addr_o = start_addr_q;
  assign trig_addr_o  = trig_addr_q;
  assign triggered_o  = triggered_q;
  assign done_o       = done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Directed bench for acq_trigger_ctrl: one task per scenario, inline checks,
// write monitor capturing every RAM write into queues.
module tb_acq_trigger_ctrl;

  localparam int A_REQ = 3;
  localparam int A_SET = 4;
  localparam int A_LVL = 5;
  localparam int A_PRE = 6;
  localparam int A_NUM = 7;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adc_data_i = '0;
  logic        adc_rdy_i = 1'b0;
  logic [15:0] reg_si_data = '0;
  logic [7:0]  reg_si_addr = '0;
  logic        reg_si_rdy = 1'b0;
  logic        buf_we_o;
  logic [7:0]  buf_addr_o;
  logic [7:0]  buf_data_o;
  logic [7:0]  start_addr_o;
  logic [7:0]  trig_addr_o;
  logic        triggered_o;
  logic        done_o;
  logic [2:0]  state_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];

  acq_trigger_ctrl dut (
    .clk_i        (clk_i),
    .rst          (rst),
    .adc_data_i   (adc_data_i),
    .adc_rdy_i    (adc_rdy_i),
    .reg_si_data  (reg_si_data),
    .reg_si_addr  (reg_si_addr),
    .reg_si_rdy   (reg_si_rdy),
    .buf_we_o     (buf_we_o),
    .buf_addr_o   (buf_addr_o),
    .buf_data_o   (buf_data_o),
    .start_addr_o (start_addr_o),
    .trig_addr_o  (trig_addr_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .state_o      (state_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  // write monitor, sampled away from the active edge
  always @(negedge clk_i) begin
    if (buf_we_o) begin
      wr_addr_q.push_back(buf_addr_o);
      wr_data_q.push_back(buf_data_o);
    end
  end

  // drivers: every task starts and ends on a falling edge
  task automatic reg_write(input int addr, input int data);
    reg_si_addr = 8'(addr);
    reg_si_data = 16'(data);
    reg_si_rdy  = 1'b1;
    @(negedge clk_i);
    reg_si_rdy  = 1'b0;
  endtask

  task automatic send_sample(input logic [7:0] d, input int gap);
    adc_data_i = d;
    adc_rdy_i  = 1'b1;
    @(negedge clk_i);
    adc_rdy_i  = 1'b0;
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic write_with_sample(input int addr, input int data, input logic [7:0] d);
    reg_si_addr = 8'(addr);
    reg_si_data = 16'(data);
    reg_si_rdy  = 1'b1;
    adc_data_i  = d;
    adc_rdy_i   = 1'b1;
    @(negedge clk_i);
    reg_si_rdy  = 1'b0;
    adc_rdy_i   = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_i);
    rst = 1'b0;
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if (buf_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%0d exp=0", buf_we_o); end
    checks++; if (buf_addr_o !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", buf_addr_o); end
    checks++; if (buf_data_o !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", buf_data_o); end
    checks++; if (start_addr_o !== 8'd0) begin failures++; $display("FAIL reset_start_addr got=%0d exp=0", start_addr_o); end
    checks++; if (trig_addr_o !== 8'd0) begin failures++; $display("FAIL reset_trig_addr got=%0d exp=0", trig_addr_o); end
    checks++; if (triggered_o !== 1'b0) begin failures++; $display("FAIL reset_triggered got=%0d exp=0", triggered_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", done_o); end
  endtask

  // defaults: L=128 rising, pre=64, n=256; ramp one sample every 4 clocks
  task automatic test_ramp_defaults();
    clear_log();
    reg_write(A_REQ, 1);
    checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL ramp_start_state got=%0d exp=1", state_o); end
    for (int i = 0; i < 320; i++) begin
      send_sample(8'(i), 3);
      if (i == 62) begin
        checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL ramp_pre63 got=%0d exp=1", state_o); end
      end
      if (i == 63) begin
        checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL ramp_armed got=%0d exp=2", state_o); end
      end
      if (i == 127) begin
        checks++; if (triggered_o !== 1'b0) begin failures++; $display("FAIL ramp_early_trig got=%0d exp=0", triggered_o); end
      end
      if (i == 128) begin
        checks++; if (triggered_o !== 1'b1) begin failures++; $display("FAIL ramp_trig got=%0d exp=1", triggered_o); end
        checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL ramp_post_state got=%0d exp=3", state_o); end
        checks++; if (trig_addr_o !== 8'd128) begin failures++; $display("FAIL ramp_trig_addr got=%0d exp=128", trig_addr_o); end
        checks++; if (start_addr_o !== 8'd64) begin failures++; $display("FAIL ramp_start_addr got=%0d exp=64", start_addr_o); end
      end
      if (i == 318) begin
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL ramp_done_early got=%0d exp=0", done_o); end
      end
      if (i == 319) begin
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL ramp_done got=%0d exp=1", done_o); end
        checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL ramp_done_state got=%0d exp=4", state_o); end
      end
    end
    checks++; if (wr_addr_q.size() !== 320) begin failures++; $display("FAIL ramp_write_count got=%0d exp=320", wr_addr_q.size()); end
    if (wr_addr_q.size() == 320) begin
      checks++; if (wr_data_q[128] !== 8'd128) begin failures++; $display("FAIL ramp_trig_data got=%0d exp=128", wr_data_q[128]); end
      checks++; if (wr_addr_q[319] !== 8'd63) begin failures++; $display("FAIL ramp_wrap_addr got=%0d exp=63", wr_addr_q[319]); end
    end
    send_sample(8'd7, 2);
    checks++; if (wr_addr_q.size() !== 320) begin failures++; $display("FAIL ramp_no_write_done got=%0d exp=320", wr_addr_q.size()); end
  endtask

  task automatic test_falling();
    clear_log();
    reg_write(A_SET, 1);
    reg_write(A_LVL, 100);
    reg_write(A_PRE, 0);
    reg_write(A_NUM, 4);
    reg_write(A_REQ, 1);
    checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL fall_direct_arm got=%0d exp=2", state_o); end
    send_sample(8'd200, 1);
    send_sample(8'd150, 1);
    send_sample(8'd100, 1);
    checks++; if (triggered_o !== 1'b0) begin failures++; $display("FAIL fall_not_on_100 got=%0d exp=0", triggered_o); end
    send_sample(8'd99, 1);
    checks++; if (triggered_o !== 1'b1) begin failures++; $display("FAIL fall_trig got=%0d exp=1", triggered_o); end
    checks++; if (trig_addr_o !== 8'd3) begin failures++; $display("FAIL fall_trig_addr got=%0d exp=3", trig_addr_o); end
    checks++; if (start_addr_o !== 8'd3) begin failures++; $display("FAIL fall_start_addr got=%0d exp=3", start_addr_o); end
    if (wr_data_q.size() == 4) begin
      checks++; if (wr_data_q[3] !== 8'd99) begin failures++; $display("FAIL fall_trig_data got=%0d exp=99", wr_data_q[3]); end
    end
    send_sample(8'd0, 1);
    send_sample(8'd0, 1);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL fall_done_early got=%0d exp=0", done_o); end
    send_sample(8'd0, 1);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL fall_done got=%0d exp=1", done_o); end
  endtask

  task automatic test_force();
    clear_log();
    reg_write(A_SET, 0);
    reg_write(A_LVL, 128);
    reg_write(A_PRE, 10);
    reg_write(A_NUM, 20);
    reg_write(A_REQ, 1);
    reg_write(A_REQ, 4);  // force during PRE_FILL must be forgotten
    for (int i = 0; i < 30; i++) send_sample(8'd50, 1);
    checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL force_armed got=%0d exp=2", state_o); end
    checks++; if (triggered_o !== 1'b0) begin failures++; $display("FAIL force_stale got=%0d exp=0", triggered_o); end
    reg_write(A_REQ, 4);
    checks++; if (triggered_o !== 1'b0) begin failures++; $display("FAIL force_no_sample got=%0d exp=0", triggered_o); end
    send_sample(8'd50, 1);
    checks++; if (triggered_o !== 1'b1) begin failures++; $display("FAIL force_trig got=%0d exp=1", triggered_o); end
    checks++; if (trig_addr_o !== 8'd30) begin failures++; $display("FAIL force_trig_addr got=%0d exp=30", trig_addr_o); end
    checks++; if (start_addr_o !== 8'd20) begin failures++; $display("FAIL force_start_addr got=%0d exp=20", start_addr_o); end
    for (int i = 0; i < 8; i++) send_sample(8'd50, 1);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL force_done_early got=%0d exp=0", done_o); end
    send_sample(8'd50, 1);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL force_done got=%0d exp=1", done_o); end
    checks++; if (wr_addr_q.size() !== 40) begin failures++; $display("FAIL force_write_count got=%0d exp=40", wr_addr_q.size()); end
  endtask

  task automatic test_clamp();
    clear_log();
    reg_write(A_LVL, 128);
    reg_write(A_PRE, 300);
    reg_write(A_NUM, 0);
    reg_write(A_REQ, 1);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL clamp_done_cleared got=%0d exp=0", done_o); end
    checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL clamp_pre1 got=%0d exp=1", state_o); end
    send_sample(8'd10, 1);
    checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL clamp_armed got=%0d exp=2", state_o); end
    send_sample(8'd200, 1);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL clamp_done got=%0d exp=1", done_o); end
    checks++; if (trig_addr_o !== 8'd1) begin failures++; $display("FAIL clamp_trig_addr got=%0d exp=1", trig_addr_o); end
    checks++; if (start_addr_o !== 8'd0) begin failures++; $display("FAIL clamp_start_addr got=%0d exp=0", start_addr_o); end
    send_sample(8'd5, 1);
    checks++; if (wr_addr_q.size() !== 2) begin failures++; $display("FAIL clamp_write_count got=%0d exp=2", wr_addr_q.size()); end
    // oversize length saturates to full depth
    clear_log();
    reg_write(A_NUM, 512);
    reg_write(A_PRE, 0);
    reg_write(A_REQ, 1);
    reg_write(A_REQ, 4);
    for (int i = 0; i < 256; i++) begin
      send_sample(8'(i), 1);
      if (i == 0) begin
        checks++; if (triggered_o !== 1'b1) begin failures++; $display("FAIL big_force_trig got=%0d exp=1", triggered_o); end
      end
      if (i == 254) begin
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL big_done_early got=%0d exp=0", done_o); end
      end
    end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL big_done got=%0d exp=1", done_o); end
    checks++; if (wr_addr_q.size() !== 256) begin failures++; $display("FAIL big_write_count got=%0d exp=256", wr_addr_q.size()); end
  endtask

  task automatic test_abort();
    clear_log();
    reg_write(A_SET, 0);
    reg_write(A_LVL, 128);
    reg_write(A_PRE, 2);
    reg_write(A_NUM, 8);
    reg_write(A_REQ, 1);
    send_sample(8'd0, 1);
    send_sample(8'd0, 1);
    send_sample(8'd200, 1);
    send_sample(8'd5, 1);
    checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL abort_in_post got=%0d exp=3", state_o); end
    write_with_sample(A_REQ, 2, 8'd9);
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", state_o); end
    checks++; if (buf_we_o !== 1'b0) begin failures++; $display("FAIL abort_we got=%0d exp=0", buf_we_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_o); end
    checks++; if (triggered_o !== 1'b1) begin failures++; $display("FAIL abort_trig_kept got=%0d exp=1", triggered_o); end
    @(negedge clk_i);
    checks++; if (wr_addr_q.size() !== 4) begin failures++; $display("FAIL abort_write_count got=%0d exp=4", wr_addr_q.size()); end
    reg_write(A_REQ, 1);
    checks++; if (triggered_o !== 1'b0) begin failures++; $display("FAIL restart_trig_clr got=%0d exp=0", triggered_o); end
    reg_write(A_REQ, 3);
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL start_abort_state got=%0d exp=0", state_o); end
  endtask

  task automatic test_reset_mid_capture();
    clear_log();
    reg_write(A_PRE, 0);
    reg_write(A_NUM, 10);
    reg_write(A_LVL, 200);
    reg_write(A_REQ, 1);
    send_sample(8'd10, 1);
    send_sample(8'd20, 1);
    checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL mid_wait got=%0d exp=2", state_o); end
    rst = 1'b1;
    adc_data_i = 8'd30;
    adc_rdy_i = 1'b1;
    @(negedge clk_i);
    rst = 1'b0;
    adc_rdy_i = 1'b0;
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL mid_rst_state got=%0d exp=0", state_o); end
    checks++; if (buf_addr_o !== 8'd0) begin failures++; $display("FAIL mid_rst_addr got=%0d exp=0", buf_addr_o); end
    checks++; if (buf_data_o !== 8'd0) begin failures++; $display("FAIL mid_rst_data got=%0d exp=0", buf_data_o); end
    checks++; if (buf_we_o !== 1'b0) begin failures++; $display("FAIL mid_rst_we got=%0d exp=0", buf_we_o); end
    clear_log();
    write_with_sample(A_REQ, 1, 8'd77);
    checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL mid_default_pre got=%0d exp=1", state_o); end
    checks++; if (buf_we_o !== 1'b0) begin failures++; $display("FAIL start_sample_dropped got=%0d exp=0", buf_we_o); end
    send_sample(8'd5, 1);
    checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("FAIL mid_write_count got=%0d exp=1", wr_addr_q.size()); end
    if (wr_addr_q.size() == 1) begin
      checks++; if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 8'd5) begin
        failures++; $display("FAIL mid_first_write got=%0d/%0d exp=0/5", wr_addr_q[0], wr_data_q[0]);
      end
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_ramp_defaults();
    test_falling();
    test_force();
    test_clamp();
    test_abort();
    test_reset_mid_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
